// File: rtl/cla_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial shared-adder controller.
package cla_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_DEFAULT = 4;

  // Width of the nibble counter; at least one bit, even when there is a single nibble.
  function automatic int cnt_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla_shared_adder_ctrl_if.sv
// Request and response channels between the two clients and the shared adder.
interface cla_shared_adder_ctrl_if
  import cla_ctrl_pkg::*;
#(
  parameter int NIB = NIB_DEFAULT
);
  localparam int W = 4 * NIB;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;

  // Client side: issues operations and consumes results.
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output rsp_ready
  );

  // Adder side: accepts operations and produces results.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  rsp_ready
  );

endinterface

// File: rtl/CLA.sv
// 4-bit carry-lookahead slice: all four carries are formed from generate/propagate terms.
module CLA (
  output logic [3:0] SUM,
  output logic       C_OUT,
  input  logic       C_IN,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Lookahead carries, sum and carry-out.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = C_IN;
    c[1] = g[0] | (p[0] & C_IN);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_IN);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C_IN);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & C_IN);
    SUM   = p ^ c[3:0];
    C_OUT = c[4];
  end

endmodule

// File: rtl/cla_shared_adder_ctrl.sv
// Two-client arbiter and sequencer driving one 4-bit CLA slice, one nibble per cycle, LSB first.
module cla_shared_adder_ctrl
  import cla_ctrl_pkg::*;
#(
  parameter int NIB = NIB_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cla_shared_adder_ctrl_if.slave   bus
);

  localparam int              W        = 4 * NIB;
  localparam int              CW       = cnt_width(NIB);
  localparam logic [CW-1:0]   CNT_LAST = CW'(NIB - 1);

  state_t         state;
  state_t         state_nxt;
  logic           last;       // id granted most recently; breaks ties toward the other client
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic           id_q;

  logic           grant0;
  logic           grant1;
  logic           take0;
  logic           take1;

  logic [3:0]     slice_a;
  logic [3:0]     slice_b;
  logic [3:0]     slice_sum;
  logic           slice_cout;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last);
  end

  // Readies are only offered in IDLE and are held low while reset is asserted.
  assign bus.req0_ready = rst_n && (state == IDLE) && grant0;
  assign bus.req1_ready = rst_n && (state == IDLE) && grant1;
  assign take0          = bus.req0_valid && bus.req0_ready;
  assign take1          = bus.req1_valid && bus.req1_ready;

  // FSM state register.
  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: the default is assigned first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take0 || take1)     state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST)    state_nxt = DONE;
      DONE:    if (bus.rsp_ready)      state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Select the current nibble of each latched operand for the slice.
  always_comb begin
    slice_a = a_q[4*int'(cnt) +: 4];
    slice_b = b_q[4*int'(cnt) +: 4];
  end

  CLA u_cla (
    .SUM   (slice_sum),
    .C_OUT (slice_cout),
    .C_IN  (carry_q),
    .A     (slice_a),
    .B     (slice_b)
  );

  // Operand capture at transfer, then one nibble of sum and the ripple carry per RUN cycle.
  // NOTE: operand and result registers are reset too, so an aborted operation leaves no stale result on rsp_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      cnt     <= '0;
      last    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (take0) begin
            a_q     <= bus.req0_a;
            b_q     <= bus.req0_b;
            carry_q <= bus.req0_cin;
            id_q    <= 1'b0;
            last    <= 1'b0;
            cnt     <= '0;
          end else if (take1) begin
            a_q     <= bus.req1_a;
            b_q     <= bus.req1_b;
            carry_q <= bus.req1_cin;
            id_q    <= 1'b1;
            last    <= 1'b1;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum_q[4*int'(cnt) +: 4] <= slice_sum;
          carry_q                 <= slice_cout;
          if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Response channel driven straight from the result registers.
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: doc/cla_shared_adder_ctrl.md
# cla_shared_adder_ctrl

Sequencer and arbiter that shares one 4-bit CLA slice (`CLA`) between two requesters to perform W-bit additions, one nibble per cycle, LSB first. Each requester hands over a full operand pair plus carry-in through a valid/ready handshake. The block returns the W-bit sum, the carry-out and the requester ID on a single response channel. It sits between the client logic and the adder datapath, replacing a full-width adder where area matters more than latency.

## Interface
- `NIB`, 4: number of nibbles per operand; W = 4*NIB; legal range 1..16
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req0_valid` in 1: requester 0 has an operation pending
- `req0_ready` out 1: requester 0 accepted this cycle
- `req0_a`, `req0_b` in W: operands
- `req0_cin` in 1: carry-in
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer takes the result
- `rsp_sum` out W: sum
- `rsp_cout` out 1: final carry-out
- `rsp_id` out 1: requester that issued the operation

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset puts it in IDLE.
- **IDLE, grant rule.** If exactly one requester is valid, it is granted. If both are valid, the requester not granted last time wins. Round-robin pointer `last` resets to 1, so req0 wins the first tie.
- **IDLE, ready.** `reqN_ready` = IDLE && `reqN_valid` && granted(N). This is combinational from valid. The other ready stays 0.
- **IDLE, transfer.** A transfer occurs when `reqN_valid && reqN_ready`. On that edge:
  - latch a, b and id
  - carry register <= cin
  - nibble counter <= 0
  - `last` <= N
  - state -> RUN
- **RUN.**
  - The slice inputs are a[4i+3:4i], b[4i+3:4i] and the carry register, where i is the counter.
  - Each cycle: sum nibble i <= slice SUM; carry <= slice C_OUT; counter++.
  - When i == NIB-1, state -> DONE.
- **DONE.**
  - `rsp_valid` = 1; `rsp_sum`, `rsp_cout` and `rsp_id` are driven from registers.
  - On `rsp_ready`, state -> IDLE.
- **Arithmetic.** {`rsp_cout`, `rsp_sum`} = a + b + cin, exactly (W+1 bits, no saturation).
- **Input stability.** Requester inputs are sampled only at the transfer edge. Changes during RUN or DONE are ignored. A requester may drop valid before it is granted; no transfer occurs.
- **Back-pressure.** Both readies are 0 in RUN and DONE.
- **Reset.** Asserting `rst_n` at any time aborts the operation and discards the partial result. No response is produced for an aborted operation.

## Timing
- **Reset values.**
  - `req0_ready`, `req1_ready`, `rsp_valid`, `rsp_cout`, `rsp_id` = 0
  - `rsp_sum` = 0
  - state = IDLE, `last` = 1, counter = 0
- **Latency.** With transfer on edge T, RUN covers cycles T..T+NIB-1 and `rsp_valid` rises in cycle T+NIB.
- **Minimum op spacing.** NIB+2 cycles: one IDLE cycle, NIB RUN cycles, one DONE cycle.
- **Response stability.** While `rsp_valid && !rsp_ready`, all rsp_* outputs hold.
- **No bypass.** The DONE -> IDLE edge and a new transfer never share a cycle.
- **Counter width.** max(1, $clog2(NIB)). The counter never wraps past NIB-1.

## Structure
- **Package `cla_ctrl_pkg`:**
  - state typedef (IDLE, RUN, DONE)
  - `NIB_DEFAULT` = 4
  - function for counter width
- **Sub-module:** a single instance of the existing `CLA` slice, using port order SUM, C_OUT, C_IN, A, B.
- **Top-level contents:** FSM, arbiter, operand and result registers.

## Test plan
All scenarios use NIB = 4.
1. **Reset.** Hold `rst_n` low with both valids high -> all outputs 0. After release, the first grant goes to req0.
2. **Single op.** req0 sends a=0xFFFF, b=0x0001, cin=0 -> `rsp_valid` 4 cycles after transfer, with sum=0x0000, cout=1, id=0.
3. **Simultaneous requests.**
   - Both valid: req0 sends 0x1234+0x4321 cin=1; req1 sends 0x00FF+0x0001 cin=0.
   - First response: id=0, sum=0x5556, cout=0. Second response: id=1, sum=0x0100, cout=0.
   - A further tie grants req0.
4. **Back-pressure.** Hold `rsp_ready`=0 for 3 cycles in DONE -> rsp outputs stable, both readies 0. Next transfer is no earlier than one cycle after the handshake.
5. **Reset mid-RUN.** Assert reset after 2 nibbles -> `rsp_valid` never rises and outputs are 0. The following op 0x8000+0x8000, cin=1 -> sum=0x0001, cout=1.
6. **Operand change.** Change `req1_a` and `req1_b` during RUN -> result matches the values latched at transfer.
